// File: rtl/uart_pkg.sv
// Purpose : shared types and line-level constants for the UART receive path.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_rx_sampler.sv
// Purpose : synchronise RX, keep the per-bit tick phase and majority-vote each bit.
// Latency : 2 cycles synchroniser; bit value resolved at tick OVERSAMPLE/2+1.
// Backpressure: none; free-running, phase restarted by start_pulse_i.
//
// Ports:
//   clk_i, rst_i    receiver clock, synchronous active-high reset
//   rx_i            asynchronous serial line
//   start_pulse_i   FSM saw the start edge this cycle (that cycle is tick 0)
//   rx_s_o          synchronised line
//   rx_vld_o        rx_s_o reflects the real line (synchroniser refilled after reset)
//   bit_val_o       3-sample majority, meaningful only when bit_strobe_o=1
//   bit_strobe_o    resolve tick
//   bit_end_o       last tick of the bit
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    input  logic start_pulse_i,
    output logic rx_s_o,
    output logic rx_vld_o,
    output logic bit_val_o,
    output logic bit_strobe_o,
    output logic bit_end_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_SAMP0 = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] T_SAMP1 = TW'(OVERSAMPLE/2);
    localparam logic [TW-1:0] T_RES   = TW'(OVERSAMPLE/2 + 1);
    localparam logic [TW-1:0] T_END   = TW'(OVERSAMPLE - 1);

    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;
    logic [1:0]    samp_q;
    logic          rx_s;

    assign rx_s = sync_q[1];

    // The start-edge cycle counts as tick 0, so the next cycle is tick 1.
    always_comb begin
        tick_d = tick_q + TW'(1);
        if (start_pulse_i) begin
            tick_d = TW'(1);
        end else if (tick_q == T_END) begin
            tick_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {LINE_IDLE, LINE_IDLE};
            fill_q <= '0;
            tick_q <= '0;
            samp_q <= '0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            // Both flops still hold reset values for two cycles; the arming
            // logic must not mistake them for a genuinely idle line.
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            tick_q <= tick_d;
            if (tick_q == T_SAMP0) begin
                samp_q[0] <= rx_s;
            end
            if (tick_q == T_SAMP1) begin
                samp_q[1] <= rx_s;
            end
        end
    end

    // Third sample is the live value at the resolve tick.
    assign bit_val_o    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign bit_strobe_o = (tick_q == T_RES);
    assign bit_end_o    = (tick_q == T_END);
    assign rx_s_o       = rx_s;
    assign rx_vld_o     = (fill_q == 2'd2);

endmodule

// File: rtl/uart_rx.sv
// Purpose : UART receiver: start/data/parity/stop deserialiser with error flags.
// Latency : result registered 1 cycle after stop-bit resolve (3 cycles after mid-stop incl. sync).
// Backpressure: none; results are single-cycle pulses, P_DATA holds the last good word.
//
// Ports:
//   CLK, RST          receiver clock (OVERSAMPLE x bit rate), synchronous active-high reset
//   RX_IN             asynchronous serial line, idles high
//   PAR_EN, PAR_TYP   parity enable / odd(1) or even(0), latched at start-bit detection
//   P_DATA            last error-free word
//   DATA_VALID        pulse: P_DATA updated
//   PAR_ERR, STP_ERR  pulses: parity mismatch / stop bit sampled 0
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int OVERSAMPLE  = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    output logic [DATA_LENGTH-1:0] P_DATA,
    output logic                   DATA_VALID,
    output logic                   PAR_ERR,
    output logic                   STP_ERR
);

    localparam int CW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_LENGTH - 1);

    rx_state_t              state_q;
    logic                   armed_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [DATA_LENGTH-1:0] shift_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic                   par_err_q;
    logic [DATA_LENGTH-1:0] p_data_q;
    logic                   data_valid_q;
    logic                   par_err_out_q;
    logic                   stp_err_q;

    logic rx_s;
    logic rx_vld;
    logic bit_val;
    logic bit_strobe;
    logic bit_end;
    logic start_pulse;

    assign start_pulse = (state_q == IDLE) && armed_q && (rx_s == START_BIT);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk_i         (CLK),
        .rst_i         (RST),
        .rx_i          (RX_IN),
        .start_pulse_i (start_pulse),
        .rx_s_o        (rx_s),
        .rx_vld_o      (rx_vld),
        .bit_val_o     (bit_val),
        .bit_strobe_o  (bit_strobe),
        .bit_end_o     (bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            armed_q       <= 1'b0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= PAR_EVEN;
            par_err_q     <= 1'b0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            par_err_out_q <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            data_valid_q  <= 1'b0;
            par_err_out_q <= 1'b0;
            stp_err_q     <= 1'b0;

            // Once a real high level has been seen the receiver stays armed,
            // so a break after a frame keeps producing framing errors.
            if (rx_vld && (rx_s == LINE_IDLE)) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        state_q   <= START;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_err_q <= 1'b0;
                    end
                end
                START: begin
                    if (bit_strobe && (bit_val == LINE_IDLE)) begin
                        state_q <= IDLE;
                    end else if (bit_end) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (bit_strobe) begin
                        shift_q <= {bit_val, shift_q[DATA_LENGTH-1:1]};
                    end
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_strobe) begin
                        par_err_q <= (bit_val != ((^shift_q) ^ par_typ_q));
                    end
                    if (bit_end) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    // Leave at the resolve tick: the remaining half bit is the
                    // margin that lets a back-to-back start edge be caught.
                    if (bit_strobe) begin
                        state_q <= IDLE;
                        if (bit_val && !par_err_q) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                        par_err_out_q <= par_err_q;
                        stp_err_q     <= ~bit_val;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_out_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    import uart_pkg::*;

    localparam int OS = 8;
    localparam int DL = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_in;
    logic         par_en;
    logic         par_typ;
    logic [DL-1:0] p_data;
    logic         dv, pe, se;

    always #5 clk = ~clk;

    uart_rx #(.DATA_LENGTH(DL), .OVERSAMPLE(OS)) dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx_in),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .DATA_VALID (dv),
        .PAR_ERR    (pe),
        .STP_ERR    (se)
    );

    typedef struct packed {
        logic         dv;
        logic         pe;
        logic         se;
        logic [DL-1:0] pd;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       pen, ptyp, pbit, stopb;
        logic       edv, epe, ese;
        logic [7:0] epd;
    } vec_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Every cycle with any result pulse becomes one observed event.
    always @(negedge clk) begin
        if (!rst && (dv || pe || se)) begin
            got_q.push_back({dv, pe, se, p_data});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Optional single-cycle inversion on line cycle OS/2 (the middle sample).
    task automatic send_bit(input logic b, input bit glitch);
        rx_in = b;
        if (glitch) begin
            cyc(OS/2);
            rx_in = ~b;
            cyc(1);
            rx_in = b;
            cyc(OS/2 - 1);
        end else begin
            cyc(OS);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic stopb, input int glitch_bit,
                              input bit scramble);
        par_en  = pen;
        par_typ = ptyp;
        send_bit(START_BIT, glitch_bit == 0);
        if (scramble) begin
            par_en  = 1'($urandom);
            par_typ = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch_bit == i + 1);
        if (pen) send_bit(pbit, 1'b0);
        send_bit(stopb, 1'b0);
    endtask

    task automatic chk_ev(input string name, input logic edv, input logic epe,
                          input logic ese, input logic [7:0] epd);
        ev_t e;
        if (got_q.size() == 0) begin
            chk({name, "_present"}, 32'd0, 32'd1);
        end else begin
            e = got_q.pop_front();
            chk({name, "_dv"}, 32'(e.dv), 32'(edv));
            chk({name, "_pe"}, 32'(e.pe), 32'(epe));
            chk({name, "_se"}, 32'(e.se), 32'(ese));
            chk({name, "_pdata"}, 32'(e.pd), 32'(epd));
        end
    endtask

    initial begin
        vec_t       tbl[7];
        logic [7:0] d, model_pd;
        logic       pen, ptyp, pbit, stopb, corrupt, e_pe, e_se, e_dv;
        int         gap, ones;

        tbl[0] = '{8'hA5, 0, 0, 0, 1, 1, 0, 0, 8'hA5};
        tbl[1] = '{8'h3C, 1, 0, 1, 1, 0, 1, 0, 8'hA5};
        tbl[2] = '{8'h3C, 1, 0, 0, 1, 1, 0, 0, 8'h3C};
        tbl[3] = '{8'h81, 0, 0, 0, 0, 0, 0, 1, 8'h3C};
        tbl[4] = '{8'h7E, 0, 0, 0, 1, 1, 0, 0, 8'h7E};
        tbl[5] = '{8'h5A, 1, 1, 1, 1, 1, 0, 0, 8'h5A};
        tbl[6] = '{8'h0F, 1, 0, 1, 0, 0, 1, 1, 8'h5A};

        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_pdata", 32'(p_data), 32'd0);
        chk("reset_dv", 32'(dv), 32'd0);
        chk("reset_pe", 32'(pe), 32'd0);
        chk("reset_se", 32'(se), 32'd0);
        @(posedge clk); #1;
        cyc(2*OS);

        // Table-driven single frames.
        for (int i = 0; i < 7; i++) begin
            got_q.delete();
            send_frame(tbl[i].d, tbl[i].pen, tbl[i].ptyp, tbl[i].pbit, tbl[i].stopb, -1, 1'b0);
            rx_in = 1'b1;
            cyc(2*OS);
            chk($sformatf("vec%0d_count", i), 32'(got_q.size()), 32'd1);
            chk_ev($sformatf("vec%0d", i), tbl[i].edv, tbl[i].epe, tbl[i].ese, tbl[i].epd);
        end

        // Short low glitch: rejected in START, back to IDLE.
        got_q.delete();
        rx_in = 1'b0;
        cyc(2);
        rx_in = 1'b1;
        cyc(OS + 1);
        chk("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        cyc(2*OS);
        chk("glitch_no_event", 32'(got_q.size()), 32'd0);

        // Back-to-back frames, second one with a mid-sample glitch in data bit 2.
        got_q.delete();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        rx_in = 1'b1;
        cyc(2*OS);
        chk("b2b_count", 32'(got_q.size()), 32'd2);
        chk_ev("b2b_first", 1'b1, 1'b0, 1'b0, 8'h55);
        chk_ev("b2b_second", 1'b1, 1'b0, 1'b0, 8'hAA);

        // Break: two full frame times low -> two framing errors; the line
        // returns high before the third start is confirmed.
        got_q.delete();
        par_en = 1'b0;
        rx_in = 1'b0;
        cyc(158);
        rx_in = 1'b1;
        cyc(3*OS);
        chk("break_count", 32'(got_q.size()), 32'd2);
        chk_ev("break_first", 1'b0, 1'b0, 1'b1, 8'hAA);
        chk_ev("break_second", 1'b0, 1'b0, 1'b1, 8'hAA);

        // Reset during data bit 4 with the line held low.
        got_q.delete();
        par_en = 1'b0;
        send_bit(START_BIT, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h12 >> i) & 8'h01) != 0, 1'b0);
        rx_in = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        chk("midrst_pdata", 32'(p_data), 32'd0);
        chk("midrst_dv", 32'(dv), 32'd0);
        chk("midrst_pe", 32'(pe), 32'd0);
        chk("midrst_se", 32'(se), 32'd0);
        cyc(3*OS);
        chk("midrst_unarmed", 32'(got_q.size()), 32'd0);
        rx_in = 1'b1;
        cyc(2*OS);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        rx_in = 1'b1;
        cyc(2*OS);
        chk("midrst_count", 32'(got_q.size()), 32'd1);
        chk_ev("midrst_frame", 1'b1, 1'b0, 1'b0, 8'h12);

        // Randomised frames against a frame-level reference model.
        got_q.delete();
        exp_q.delete();
        model_pd = 8'h12;
        for (int k = 0; k < 30; k++) begin
            d       = 8'($urandom);
            pen     = 1'($urandom);
            ptyp    = 1'($urandom);
            corrupt = ($urandom_range(0, 3) == 0);
            stopb   = ($urandom_range(0, 3) != 0);
            gap     = stopb ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            ones    = $countones(d);
            // Parity bit that makes the total count of ones even (PAR_TYP=0) or odd.
            pbit    = 1'(ones % 2) ^ ptyp ^ corrupt;
            e_pe    = pen && (((ones + int'(pbit)) % 2) != int'(ptyp));
            e_se    = !stopb;
            e_dv    = !e_pe && !e_se;
            if (e_dv) model_pd = d;
            exp_q.push_back({e_dv, e_pe, e_se, model_pd});
            send_frame(d, pen, ptyp, pbit, stopb, -1, 1'b1);
            rx_in = 1'b1;
            cyc(gap*OS);
        end
        rx_in = 1'b1;
        cyc(3*OS);
        chk("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("rand_ev%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
